// File: rtl/counter_ctrl_pkg.sv
// Shared types and defaults for the counter load controller.
package counter_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam logic [7:0]  DEFAULT_LIMIT = 8'hFF;

    // Requests are eligible in StRun and blocked in StGuard.
    typedef enum logic {
        StRun   = 1'b0,
        StGuard = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Purely combinational; the pointer is held by the caller.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_enable,
    input  logic       i_ptr,
    output logic [1:0] o_grant,
    output logic       o_ptr_next
);

    // Pick one requester; on contention the pointer decides, and the winner yields next time.
    always_comb begin
        o_grant    = 2'b00;
        o_ptr_next = i_ptr;
        if (i_enable) begin
            unique case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = i_ptr ? 2'b10 : 2'b01;
                default: o_grant = 2'b00;
            endcase
        end
        if (o_grant[0]) begin
            o_ptr_next = 1'b1;
        end else if (o_grant[1]) begin
            o_ptr_next = 1'b0;
        end
    end

endmodule

// File: rtl/counter_load_ctrl.sv
// Drives the load port of an external counter: arbitrates two requesters, enforces a
// post-grant guard window and reloads the counter when it reaches the terminal value.
module counter_load_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned      WIDTH         = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] LIMIT_DEFAULT = WIDTH'(DEFAULT_LIMIT),
    parameter int unsigned      GUARD_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req0_valid,
    input  logic [WIDTH-1:0] i_req0_data,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [WIDTH-1:0] i_req1_data,
    output logic             o_req1_ready,
    input  logic             i_cfg_limit_we,
    input  logic             i_cfg_reload_we,
    input  logic [WIDTH-1:0] i_cfg_data,
    input  logic [WIDTH-1:0] i_cnt_val,
    output logic             o_load,
    output logic [WIDTH-1:0] o_load_data,
    output logic             o_grant_id,
    output logic             o_wrap_pulse
);

    localparam int unsigned    GW         = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0]  GUARD_INIT = (GUARD_CYCLES > 0) ? GW'(GUARD_CYCLES - 1) : '0;

    state_e           r_state;
    logic [GW-1:0]    r_guard_cnt;
    logic             r_rr_ptr;
    logic             r_grant_id;
    logic             r_wrap_pulse;
    logic [WIDTH-1:0] r_limit;
    logic [WIDTH-1:0] r_reload;

    logic       w_arb_en;
    logic [1:0] w_grant;
    logic       w_ptr_next;
    logic       w_granted;
    logic       w_wrap_hit;

    // Gating with rst_n keeps every combinational output quiet while reset is held.
    assign w_arb_en   = rst_n && (r_state == StRun);
    assign w_granted  = |w_grant;
    assign w_wrap_hit = rst_n && (i_cnt_val == r_limit);

    rr_arb2 u_arb (
        .i_valid    ({i_req1_valid, i_req0_valid}),
        .i_enable   (w_arb_en),
        .i_ptr      (r_rr_ptr),
        .o_grant    (w_grant),
        .o_ptr_next (w_ptr_next)
    );

    assign o_req0_ready = w_grant[0];
    assign o_req1_ready = w_grant[1];
    assign o_load       = w_granted || w_wrap_hit;
    assign o_grant_id   = r_grant_id;
    assign o_wrap_pulse = r_wrap_pulse;

    // Load value: requester data beats the auto-reload value.
    always_comb begin
        o_load_data = '0;
        if (w_grant[0]) begin
            o_load_data = i_req0_data;
        end else if (w_grant[1]) begin
            o_load_data = i_req1_data;
        end else if (w_wrap_hit) begin
            o_load_data = r_reload;
        end
    end

    // Guard FSM, arbitration pointer, config registers and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StRun;
            r_guard_cnt  <= '0;
            r_rr_ptr     <= 1'b0;
            r_grant_id   <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_limit      <= LIMIT_DEFAULT;
            r_reload     <= '0;
        end else begin
            if (i_cfg_limit_we) begin
                r_limit <= i_cfg_data;
            end
            if (i_cfg_reload_we) begin
                r_reload <= i_cfg_data;
            end
            r_wrap_pulse <= w_wrap_hit && !w_granted;
            if (w_granted) begin
                r_rr_ptr   <= w_ptr_next;
                r_grant_id <= w_grant[1];
            end
            case (r_state)
                StRun: begin
                    if (w_granted && (GUARD_CYCLES > 0)) begin
                        r_state     <= StGuard;
                        r_guard_cnt <= GUARD_INIT;
                    end
                end
                StGuard: begin
                    if (r_guard_cnt == '0) begin
                        r_state <= StRun;
                    end else begin
                        r_guard_cnt <= r_guard_cnt - GW'(1);
                    end
                end
                default: r_state <= StRun;
            endcase
        end
    end

endmodule
